// File: rtl/lif_pkg.sv
// Shared definitions for the lif edge injector: token codes, legality check, FSM states.
package lif_pkg;

    localparam logic [3:0] TOK_N      = 4'b0001;
    localparam logic [3:0] TOK_E      = 4'b0010;
    localparam logic [3:0] TOK_S      = 4'b0100;
    localparam logic [3:0] TOK_W      = 4'b1000;
    localparam logic [3:0] TOK_PAIR_A = 4'b1010;
    localparam logic [3:0] TOK_PAIR_B = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } inj_state_e;

    function automatic logic tok_legal(input logic [3:0] tok);
        return (tok == TOK_N) || (tok == TOK_E) || (tok == TOK_S) ||
               (tok == TOK_W) || (tok == TOK_PAIR_A) || (tok == TOK_PAIR_B);
    endfunction

endpackage

// File: rtl/lif_tok_fifo.sv
// Synchronous token queue: one write and one read port, registered occupancy.
// Callers must not push when full or pop when empty.
module lif_tok_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;

endmodule

// File: rtl/lif_edge_injector.sv
// Boundary token transmitter driving one edge cell's neighbour input from a host queue.
// Optional statistics counters are built only when LIF_INJ_STATS_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for en and a queued entry; out held at 0
//  EMIT  | pulse pending; deferred while the edge cell fires toward us
//  GAP   | idle spacing after a pulse, then repeat or return to IDLE
module lif_edge_injector
    import lif_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 3,
    parameter int RX_BIT     = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_data,
    input  logic [3:0]                    edge_in,
    output logic [3:0]                    out,
    output logic                          busy,
    output logic                          err_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              tx_count,
    output logic [CNT_W-1:0]              rx_count
);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    inj_state_e    state_q;
    logic [3:0]    out_q;
    logic [3:0]    cur_q;
    logic [3:0]    rep_q;
    logic [GW-1:0] gcnt_q;
    logic          err_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          wr_fire;
    logic          push;
    logic          pop;
    logic          rx_hit;

    assign wr_ready = !fifo_full;
    assign wr_fire  = wr_valid && !fifo_full;
    assign push     = wr_fire && tok_legal(wr_data[3:0]);
    assign pop      = (state_q == IDLE) && en && !fifo_empty;
    assign rx_hit   = edge_in[RX_BIT];

    lif_tok_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (wr_data),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            cur_q   <= '0;
            rep_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_q <= '0;
                    if (pop) begin
                        cur_q   <= fifo_dout[3:0];
                        rep_q   <= fifo_dout[7:4];
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (rx_hit) begin
                        out_q <= '0;
                    end else begin
                        out_q   <= cur_q;
                        gcnt_q  <= GW'(GAP_CYCLES - 1);
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    out_q <= '0;
                    // Down-counter reaching zero marks the last idle cycle.
                    if (gcnt_q == '0) begin
                        if (rep_q != '0) begin
                            rep_q   <= rep_q - 4'd1;
                            state_q <= EMIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q - GW'(1);
                    end
                end
                default: begin
                    out_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (wr_fire && !tok_legal(wr_data[3:0])) begin
            err_q <= 1'b1;
        end
    end

`ifdef LIF_INJ_STATS_EN
    logic [CNT_W-1:0] tx_q;
    logic [CNT_W-1:0] rx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if ((state_q == EMIT) && !rx_hit && (tx_q != '1)) begin
                tx_q <= tx_q + CNT_W'(1);
            end
            if (rx_hit && (rx_q != '1)) begin
                rx_q <= rx_q + CNT_W'(1);
            end
        end
    end

    assign tx_count = tx_q;
    assign rx_count = rx_q;
`else
    assign tx_count = '0;
    assign rx_count = '0;
`endif

    // Only the RX_BIT lane of edge_in matters to this injector.
    logic unused_edge_bits;
    assign unused_edge_bits = ^edge_in;

    assign out         = out_q;
    assign err_illegal = err_q;
    assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lif_edge_injector.sv
// Directed self-checking bench for lif_edge_injector with default parameters.
module tb_lif_edge_injector;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       wr_data;
    logic [3:0]       edge_in;
    logic [3:0]       out;
    logic             busy;
    logic             err_illegal;
    logic [3:0]       fifo_level;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LIF_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    lif_edge_injector #(
        .FIFO_DEPTH (8),
        .GAP_CYCLES (3),
        .RX_BIT     (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .edge_in     (edge_in),
        .out         (out),
        .busy        (busy),
        .err_illegal (err_illegal),
        .fifo_level  (fifo_level),
        .tx_count    (tx_count),
        .rx_count    (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        edge_in  = 4'h0;
        en       = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_one(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out !== 4'h0) begin n_bad++; $display("FAIL reset_out got=%h want=0", out); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_illegal); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        n_cmp++; if (tx_count !== '0 || rx_count !== '0) begin n_bad++; $display("FAIL reset_counts got tx=%0d rx=%0d want 0", tx_count, rx_count); end
    endtask

    task automatic test_single();
        do_reset();
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%b want=1", wr_ready); end
        write_one(8'h04);
        n_cmp++; if (out !== 4'h0 || fifo_level !== 4'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_e0 got out=%h lvl=%0d busy=%b want 0/1/1", out, fifo_level, busy); end
        tick();
        n_cmp++; if (out !== 4'h0 || fifo_level !== 4'd0) begin n_bad++; $display("FAIL single_e1 got out=%h lvl=%0d want 0/0", out, fifo_level); end
        tick();
        n_cmp++; if (out !== 4'h4) begin n_bad++; $display("FAIL single_e2 got=%h want=4", out); end
        for (int k = 3; k <= 6; k++) begin
            tick();
            n_cmp++; if (out !== 4'h0) begin n_bad++; $display("FAIL single_after cyc=%0d got=%h want=0", k, out); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    endtask

    // Repeat pitch, en dropped mid-entry, and non-RX edge_in bits must not defer.
    task automatic test_repeat();
        logic [3:0] exp;
        do_reset();
        edge_in = 4'b0110;
        write_one(8'h21);
        tick();
        en = 1'b0;
        for (int k = 2; k <= 14; k++) begin
            tick();
            exp = (k == 2 || k == 6 || k == 10) ? 4'h1 : 4'h0;
            n_cmp++; if (out !== exp) begin n_bad++; $display("FAIL repeat cyc=%0d got=%h want=%h", k, out, exp); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL repeat_busy got=%b want=0", busy); end
        n_cmp++; if (tx_count !== (STATS ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL repeat_tx got=%0d want=%0d", tx_count, STATS ? 3 : 0); end
        n_cmp++; if (rx_count !== 16'd0) begin n_bad++; $display("FAIL repeat_rx got=%0d want=0", rx_count); end
        en = 1'b1;
        edge_in = 4'h0;
    endtask

    task automatic test_defer();
        do_reset();
        write_one(8'h08);
        tick();
        edge_in = 4'b0001;
        for (int k = 2; k <= 6; k++) begin
            tick();
            n_cmp++; if (out !== 4'h0) begin n_bad++; $display("FAIL defer_hold cyc=%0d got=%h want=0", k, out); end
        end
        edge_in = 4'h0;
        tick();
        n_cmp++; if (out !== 4'h8) begin n_bad++; $display("FAIL defer_pulse got=%h want=8", out); end
        tick();
        n_cmp++; if (out !== 4'h0) begin n_bad++; $display("FAIL defer_end got=%h want=0", out); end
        n_cmp++; if (rx_count !== (STATS ? 16'd5 : 16'd0)) begin n_bad++; $display("FAIL defer_rx got=%0d want=%0d", rx_count, STATS ? 5 : 0); end
        n_cmp++; if (tx_count !== (STATS ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL defer_tx got=%0d want=%0d", tx_count, STATS ? 1 : 0); end
    endtask

    task automatic test_illegal();
        int pulses;
        do_reset();
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_ready got=%b want=1", wr_ready); end
        write_one(8'h03);
        n_cmp++; if (err_illegal !== 1'b1 || fifo_level !== 4'd0) begin n_bad++; $display("FAIL illegal_flag got err=%b lvl=%0d want 1/0", err_illegal, fifo_level); end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out !== 4'h0) pulses++;
        end
        n_cmp++; if (pulses != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL illegal_emit got pulses=%0d busy=%b want 0/0", pulses, busy); end
        write_one(8'h01);
        n_cmp++; if (err_illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky got=%b want=1", err_illegal); end
        do_reset();
        n_cmp++; if (err_illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_clear got=%b want=0", err_illegal); end
    endtask

    task automatic test_fill_drain();
        logic [3:0] exp_tok [9];
        logic [3:0] got_tok [$];
        logic [3:0] prev;
        logic       fire;
        int         doubles;
        exp_tok = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'hA, 4'h1, 4'h2, 4'h8};
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 8; i++) write_one({4'h0, exp_tok[i]});
        n_cmp++; if (wr_ready !== 1'b0 || fifo_level !== 4'd8) begin n_bad++; $display("FAIL fill_full got rdy=%b lvl=%0d want 0/8", wr_ready, fifo_level); end
        wr_valid = 1'b1;
        wr_data  = 8'h08;
        tick();
        tick();
        n_cmp++; if (fifo_level !== 4'd8 || out !== 4'h0) begin n_bad++; $display("FAIL fill_stall got lvl=%0d out=%h want 8/0", fifo_level, out); end
        en = 1'b1;
        prev = 4'h0;
        doubles = 0;
        for (int c = 0; c < 60; c++) begin
            fire = wr_valid && wr_ready;
            tick();
            if (fire) wr_valid = 1'b0;
            if (out !== 4'h0) got_tok.push_back(out);
            if (out !== 4'h0 && prev !== 4'h0) doubles++;
            prev = out;
        end
        n_cmp++; if (got_tok.size() != 9) begin n_bad++; $display("FAIL drain_count got=%0d want=9", got_tok.size()); end
        for (int i = 0; i < 9 && i < got_tok.size(); i++) begin
            n_cmp++; if (got_tok[i] !== exp_tok[i]) begin n_bad++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, got_tok[i], exp_tok[i]); end
        end
        n_cmp++; if (doubles != 0 || busy !== 1'b0 || wr_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end got doubles=%0d busy=%b pending=%b want 0/0/0", doubles, busy, wr_valid); end
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        do_reset();
        write_one(8'hF2);
        write_one(8'h04);
        for (int k = 2; k <= 6; k++) tick();
        n_cmp++; if (out !== 4'h2) begin n_bad++; $display("FAIL burst_second got=%h want=2", out); end
        rst_n = 1'b0;
        tick();
        n_cmp++; if (out !== 4'h0 || fifo_level !== 4'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL burst_reset got out=%h lvl=%0d busy=%b want 0/0/0", out, fifo_level, busy); end
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (out !== 4'h0) pulses++;
        end
        n_cmp++; if (pulses != 0 || tx_count !== '0) begin n_bad++; $display("FAIL burst_after got pulses=%0d tx=%0d want 0/0", pulses, tx_count); end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        edge_in  = 4'h0;
        @(negedge clk);
        test_reset();
        test_single();
        test_repeat();
        test_defer();
        test_illegal();
        test_fill_drain();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
